mdu_div: RTL and testbench

- Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU, in the EX-stage multiply/divide path.
- Sits directly upstream of the HI/LO register pair: remainder goes to HI, quotient to LO.
- The EX-stage controller stalls the pipeline while busy=1. It writes HI/LO while ready=1.

---
 rtl/mdu_div_pkg.sv | 19 +
 rtl/mdu_div_if.sv | 24 ++
 rtl/mdu_div_step.sv | 18 +
 rtl/mdu_div.sv | 130 +++++++++++++
 tb/tb_mdu_div.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mdu_div_pkg.sv
// Shared encodings and constants for the EX-stage divider.
package mdu_div_pkg;

    localparam int              RegBus   = 32;
    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'b00,
        DIV_DIVZERO = 2'b01,
        DIV_RUN     = 2'b10,
        DIV_DONE    = 2'b11
    } div_state_t;

endpackage

// File: rtl/mdu_div_if.sv
// Request/result bundle between the EX-stage controller (master) and the divider (slave).
interface mdu_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             annul;
    logic             signed_div;
    logic [WIDTH-1:0] opdata1;
    logic [WIDTH-1:0] opdata2;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             ready;
    logic             busy;

    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  result_hi, result_lo, ready, busy
    );

    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output result_hi, result_lo, ready, busy
    );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
// Purely combinational; no latency, no flow control.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dvd_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    // The shifted remainder needs one extra bit before the subtract brings it back in range.
    logic [WIDTH:0] shifted;

    assign shifted = {rem_in, dvd_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
endmodule

// File: rtl/mdu_div.sv
// Radix-2 restoring divider for DIV/DIVU; remainder -> HI, quotient -> LO.
// Latency WIDTH+2 edges (2 on divide-by-zero); results held while start stays high in DONE.
module mdu_div
    import mdu_div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    mdu_div_if.slave   bus
);
    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] rem, rem_nxt;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;
    logic             neg_q, neg_r;
    logic             q_bit;
    logic             busy_int;
    logic [WIDTH-1:0] result_hi, result_lo;

    logic             req;
    logic             run_last;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign req      = (bus.start == DivStart) && !bus.annul;
    assign run_last = (cnt == CNT_W'(WIDTH));
    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign abs_a = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
    assign abs_b = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

    // dq holds the remaining dividend bits at the top and collects quotient bits at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .divisor (dvs),
        .dvd_bit (dq[WIDTH-1]),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_nxt = state;
        busy_int  = 1'b0;
        case (state)
            DIV_IDLE: begin
                if (req) begin
                    busy_int  = 1'b1;
                    state_nxt = (bus.opdata2 == '0) ? DIV_DIVZERO : DIV_RUN;
                end
            end
            DIV_DIVZERO: begin
                busy_int  = 1'b1;
                state_nxt = bus.annul ? DIV_IDLE : DIV_DONE;
            end
            DIV_RUN: begin
                busy_int = 1'b1;
                if (bus.annul) begin
                    state_nxt = DIV_IDLE;
                end else if (run_last) begin
                    state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!req) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= DIV_IDLE;
            rem       <= '0;
            dq        <= '0;
            dvs       <= '0;
            cnt       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            result_hi <= '0;
            result_lo <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                DIV_IDLE: begin
                    if (req && (bus.opdata2 != '0)) begin
                        dq    <= abs_a;
                        dvs   <= abs_b;
                        rem   <= '0;
                        cnt   <= '0;
                        neg_q <= bus.signed_div && (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
                        neg_r <= bus.signed_div && bus.opdata1[WIDTH-1];
                    end
                end
                DIV_DIVZERO: begin
                    result_hi <= '0;
                    result_lo <= '0;
                end
                DIV_RUN: begin
                    if (bus.annul) begin
                        result_hi <= '0;
                        result_lo <= '0;
                    end else if (!run_last) begin
                        rem <= rem_nxt;
                        dq  <= {dq[WIDTH-2:0], q_bit};
                        cnt <= cnt + 1'b1;
                    end else begin
                        // Quotient truncates toward zero; remainder takes the dividend's sign.
                        result_lo <= neg_q ? -dq  : dq;
                        result_hi <= neg_r ? -rem : rem;
                    end
                end
                DIV_DONE: begin
                    if (!req) begin
                        result_hi <= '0;
                        result_lo <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result_hi = result_hi;
    assign bus.result_lo = result_lo;
    assign bus.ready     = (state == DIV_DONE) ? DivResultReady : DivResultNotReady;
    assign bus.busy      = busy_int && !reset;
endmodule

// File: tb/tb_mdu_div.sv
// Directed bench for mdu_div with an arithmetic reference model and a per-cycle output monitor.
module tb_mdu_div;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_lo = '0;
    logic [31:0] exp_hi = '0;

    mdu_div_if #(.WIDTH(32)) bus ();

    mdu_div #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division; 64-bit signed arithmetic makes the -2^31/-1 wrap fall out naturally.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end
    endfunction

    // Monitor: valid results only while ready, zeros otherwise.
    always @(negedge clk) begin
        if (bus.ready) begin
            check("mon_lo", {32'd0, bus.result_lo}, {32'd0, exp_lo});
            check("mon_hi", {32'd0, bus.result_hi}, {32'd0, exp_hi});
            check("mon_busy_done", {63'd0, bus.busy}, 64'd0);
        end else begin
            check("mon_idle_zero", {bus.result_hi, bus.result_lo}, 64'd0);
        end
    end

    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] lit_lo, input logic [31:0] lit_hi, input int lat);
        logic [31:0] mq, mr;
        int edges;
        bit seen;
        model(a, b, s, mq, mr);
        check("model_lo", {32'd0, mq}, {32'd0, lit_lo});
        check("model_hi", {32'd0, mr}, {32'd0, lit_hi});
        exp_lo = mq;
        exp_hi = mr;
        @(negedge clk);
        bus.start = 1'b1;
        bus.opdata1 = a;
        bus.opdata2 = b;
        bus.signed_div = s;
        #1 check("busy_on_request", {63'd0, bus.busy}, 64'd1);
        edges = 0;
        seen  = 0;
        while (edges < 60 && !seen) begin
            @(posedge clk);
            edges++;
            if (edges == 1) begin
                #1;
                bus.opdata1 = $urandom;
                bus.opdata2 = $urandom;
                bus.signed_div = ~s;
            end
            @(negedge clk);
            if (bus.ready) seen = 1;
        end
        check("latency", 64'(edges), 64'(lat));
        check("lit_lo", {32'd0, bus.result_lo}, {32'd0, lit_lo});
        check("lit_hi", {32'd0, bus.result_hi}, {32'd0, lit_hi});
        @(negedge clk);
        check("hold_ready", {63'd0, bus.ready}, 64'd1);
        check("hold_lo", {32'd0, bus.result_lo}, {32'd0, lit_lo});
        bus.start = 1'b0;
        @(negedge clk);
        check("drop_ready", {63'd0, bus.ready}, 64'd0);
        check("drop_results", {bus.result_hi, bus.result_lo}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.annul = 1'b0;
        bus.signed_div = 1'b0;
        bus.opdata1 = '0;
        bus.opdata2 = '0;
        #12;
        check("rst_ready", {63'd0, bus.ready}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_results", {bus.result_hi, bus.result_lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div(32'd7,          32'd2,          1'b0, 32'h00000003, 32'h00000001, 34);
        run_div(32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 34);
        run_div(32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD, 32'h00000001, 34);
        run_div(32'h12345678,   32'd0,          1'b0, 32'h00000000, 32'h00000000, 2);
        run_div(32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000, 32'h00000000, 34);
        run_div(32'hFFFFFFFF,   32'h00000001,   1'b0, 32'hFFFFFFFF, 32'h00000000, 34);
        run_div(32'd5,          32'd9,          1'b0, 32'h00000000, 32'h00000005, 34);

        // Annul partway through RUN: back to IDLE next edge, ready never rises.
        exp_lo = '0;
        exp_hi = '0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.opdata1 = 32'd1000;
        bus.opdata2 = 32'd3;
        bus.signed_div = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("annul_no_ready", {63'd0, bus.ready}, 64'd0);
        end
        bus.annul = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check("annul_ready", {63'd0, bus.ready}, 64'd0);
        check("annul_busy", {63'd0, bus.busy}, 64'd0);
        bus.annul = 1'b0;
        run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 34);

        // Asynchronous reset between edges mid-RUN.
        @(negedge clk);
        bus.start = 1'b1;
        bus.opdata1 = 32'd50;
        bus.opdata2 = 32'd7;
        repeat (15) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", {63'd0, bus.ready}, 64'd0);
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_results", {bus.result_hi, bus.result_lo}, 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 34);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
